// File: rtl/hpm_trace_pkg.sv
// Shared definitions for the HPM trace window controller.
//   CSR_MCOUNTINHIBIT : CSR address written to gate the hardware performance counters.
//   INHIBIT_NONE      : write data that enables all counters (opens a window).
//   INHIBIT_ALL       : write data that inhibits all counters (closes a window).
//   hpm_state_e       : sequencer states of hpm_window_ctrl.
package hpm_trace_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [31:0] INHIBIT_NONE      = 32'h0000_0000;
    localparam logic [31:0] INHIBIT_ALL       = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        EN_REQ,
        WINDOW,
        DIS_REQ,
        GAP
    } hpm_state_e;

endpackage

// File: rtl/hpm_interval_timer.sv
// Loadable down-counter shared by the window and gap phases.
// Ports:
//   clk_h    : clock
//   rst_h    : synchronous active-high reset
//   load_i   : load value_i this cycle (takes priority over counting)
//   value_i  : count to load
//   expire_o : high while the count is 1, i.e. the last cycle of the interval
module hpm_interval_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_h,
    input  logic             rst_h,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hpm_window_ctrl.sv
// Drives mcountinhibit through a req/gnt CSR write port to open and close
// counter sampling windows, repeating for a programmed number of packets.
// Ports:
//   clk_h, rst_h       : clock, synchronous active-high reset
//   start_i            : start pulse (ignored while busy)
//   abort_i            : early termination request (ignored while idle)
//   window_len_i       : cycles per window (0 acts as 1), latched at start
//   gap_len_i          : idle cycles between windows (0 = none), latched at start
//   num_pkts_i         : packets to run (0 = until abort), latched at start
//   csr_req_o/gnt_i    : CSR write handshake
//   csr_add_o/data_o   : CSR address/data, zero when no request
//   pkt_num_o          : completed-packet count
//   tracing_o, busy_o  : window active, sequence in progress
//   done_o             : one-cycle pulse on the edge the sequence ends
module hpm_window_ctrl
    import hpm_trace_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PKT_W = 32
) (
    input  logic             clk_h,
    input  logic             rst_h,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] window_len_i,
    input  logic [CNT_W-1:0] gap_len_i,
    input  logic [CNT_W-1:0] num_pkts_i,
    output logic             csr_req_o,
    input  logic             csr_gnt_i,
    output logic [11:0]      csr_add_o,
    output logic [31:0]      csr_data_o,
    output logic [PKT_W-1:0] pkt_num_o,
    output logic             tracing_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CMP_W = (PKT_W > CNT_W) ? PKT_W : CNT_W;

    hpm_state_e       state_q, state_d;
    logic [CNT_W-1:0] win_q, win_d, gap_q, gap_d, num_q, num_d;
    logic [PKT_W-1:0] pkt_q, pkt_d, pkt_inc;
    logic             abort_q, abort_d;
    logic             abort_any, last_pkt;
    logic             tmr_load, tmr_expire;
    logic [CNT_W-1:0] tmr_val, win_eff;

    // An abort raised in the same cycle as a decision counts immediately.
    assign abort_any = abort_q | abort_i;
    assign win_eff   = (win_q == '0) ? CNT_W'(1) : win_q;
    assign pkt_inc   = pkt_q + PKT_W'(1);
    assign last_pkt  = (num_q != '0) && (CMP_W'(pkt_inc) == CMP_W'(num_q));

    hpm_interval_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_h    (clk_h),
        .rst_h    (rst_h),
        .load_i   (tmr_load),
        .value_i  (tmr_val),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        gap_d      = gap_q;
        num_d      = num_q;
        pkt_d      = pkt_q;
        abort_d    = abort_any;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        csr_req_o  = 1'b0;
        csr_add_o  = '0;
        csr_data_o = '0;
        tracing_o  = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_o  = 1'b0;
                abort_d = 1'b0;
                if (start_i) begin
                    win_d   = window_len_i;
                    gap_d   = gap_len_i;
                    num_d   = num_pkts_i;
                    pkt_d   = '0;
                    state_d = EN_REQ;
                end
            end
            EN_REQ: begin
                csr_req_o  = 1'b1;
                csr_add_o  = CSR_MCOUNTINHIBIT;
                csr_data_o = INHIBIT_NONE;
                if (csr_gnt_i) begin
                    if (abort_any) begin
                        state_d = DIS_REQ;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = win_eff;
                        state_d  = WINDOW;
                    end
                end
            end
            WINDOW: begin
                tracing_o = 1'b1;
                if (tmr_expire || abort_any) begin
                    state_d = DIS_REQ;
                end
            end
            DIS_REQ: begin
                csr_req_o  = 1'b1;
                csr_add_o  = CSR_MCOUNTINHIBIT;
                csr_data_o = INHIBIT_ALL;
                tracing_o  = 1'b1;
                if (csr_gnt_i) begin
                    pkt_d = pkt_inc;
                    if (abort_any || last_pkt) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end else if (gap_q == '0) begin
                        state_d = EN_REQ;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = gap_q;
                        state_d  = GAP;
                    end
                end
            end
            GAP: begin
                // Counters are already inhibited here, so abort needs no CSR write.
                if (abort_i) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end else if (tmr_expire) begin
                    state_d = EN_REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset-forced return to IDLE is not a sequence completion.
        if (rst_h) begin
            done_o = 1'b0;
        end
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            state_q <= IDLE;
            win_q   <= '0;
            gap_q   <= '0;
            num_q   <= '0;
            pkt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            gap_q   <= gap_d;
            num_q   <= num_d;
            pkt_q   <= pkt_d;
            abort_q <= abort_d;
        end
    end

    assign pkt_num_o = pkt_q;

endmodule

// File: tb/tb_hpm_window_ctrl.sv
// Self-checking bench for hpm_window_ctrl: directed scenarios plus random
// stimulus, checked every cycle against a phase/elapsed-count model.
module tb_hpm_window_ctrl;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned PKT_W = 32;

    logic             clk_h = 1'b0;
    logic             rst_h, start_i, abort_i, csr_gnt_i;
    logic [CNT_W-1:0] window_len_i, gap_len_i, num_pkts_i;
    logic             csr_req_o, tracing_o, busy_o, done_o;
    logic [11:0]      csr_add_o;
    logic [31:0]      csr_data_o;
    logic [PKT_W-1:0] pkt_num_o;

    always #5 clk_h = ~clk_h;

    hpm_window_ctrl #(
        .CNT_W (CNT_W),
        .PKT_W (PKT_W)
    ) dut (
        .clk_h        (clk_h),
        .rst_h        (rst_h),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .window_len_i (window_len_i),
        .gap_len_i    (gap_len_i),
        .num_pkts_i   (num_pkts_i),
        .csr_req_o    (csr_req_o),
        .csr_gnt_i    (csr_gnt_i),
        .csr_add_o    (csr_add_o),
        .csr_data_o   (csr_data_o),
        .pkt_num_o    (pkt_num_o),
        .tracing_o    (tracing_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = -1;
    int t0     = 0;

    // Model: current phase name, cycles spent in the phase, latched config.
    string       m_ph = "idle";
    int unsigned m_el, m_win, m_gap, m_num;
    logic [31:0] m_pkt = '0;
    bit          m_ab = 1'b0;

    // Event logs (cycle numbers relative to t0) produced by the model.
    int m_en_t[$], m_dis_t[$], m_tr_t[$], m_done_t[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick(input bit st, input bit ab, input bit gn, input bit rs,
                        input int unsigned w, input int unsigned g, input int unsigned n);
        bit          e_req, e_trace, e_busy, e_done, any_ab, last;
        logic [11:0] e_add;
        logic [31:0] e_data;
        int          rel;
        @(posedge clk_h);
        #1;
        start_i      = st;
        abort_i      = ab;
        csr_gnt_i    = gn;
        rst_h        = rs;
        window_len_i = w;
        gap_len_i    = g;
        num_pkts_i   = n;
        cyc++;
        rel = cyc - t0;
        @(negedge clk_h);

        any_ab  = m_ab | ab;
        last    = (m_num != 0) && ((m_pkt + 32'd1) == m_num);
        e_req   = (m_ph == "open") || (m_ph == "close");
        e_add   = e_req ? 12'h320 : 12'h000;
        e_data  = (m_ph == "close") ? 32'hFFFF_FFFF : 32'h0;
        e_trace = (m_ph == "window") || (m_ph == "close");
        e_busy  = (m_ph != "idle");
        e_done  = !rs && (((m_ph == "close") && gn && (any_ab || last)) ||
                          ((m_ph == "gap") && ab));

        chk("req", csr_req_o, e_req);
        chk("add", csr_add_o, e_add);
        chk("data", csr_data_o, e_data);
        chk("tracing", tracing_o, e_trace);
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
        chk("pkt_num", pkt_num_o, m_pkt);

        if (e_req && gn) begin
            if (m_ph == "close") m_dis_t.push_back(rel);
            else m_en_t.push_back(rel);
        end
        if (e_trace) m_tr_t.push_back(rel);
        if (e_done) m_done_t.push_back(rel);

        // Advance the model to the next cycle.
        if (rs) begin
            m_ph  = "idle";
            m_pkt = '0;
            m_ab  = 1'b0;
            m_win = 0;
            m_gap = 0;
            m_num = 0;
            m_el  = 0;
        end else if (m_ph == "idle") begin
            m_ab = 1'b0;
            if (st) begin
                m_win = w;
                m_gap = g;
                m_num = n;
                m_pkt = '0;
                m_ph  = "open";
            end
        end else if (m_ph == "open") begin
            m_ab = any_ab;
            if (gn) begin
                m_ph = any_ab ? "close" : "window";
                m_el = 0;
            end
        end else if (m_ph == "window") begin
            m_ab = any_ab;
            m_el++;
            if (any_ab || m_el >= ((m_win == 0) ? 1 : m_win)) m_ph = "close";
        end else if (m_ph == "close") begin
            m_ab = any_ab;
            if (gn) begin
                m_pkt = m_pkt + 32'd1;
                if (any_ab || last) m_ph = "idle";
                else if (m_gap == 0) m_ph = "open";
                else begin
                    m_ph = "gap";
                    m_el = 0;
                end
            end
        end else begin
            m_ab = any_ab;
            if (ab) m_ph = "idle";
            else begin
                m_el++;
                if (m_el >= m_gap) m_ph = "open";
            end
        end
    endtask

    task automatic new_test();
        t0 = cyc + 1;
        m_en_t.delete();
        m_dis_t.delete();
        m_tr_t.delete();
        m_done_t.delete();
    endtask

    initial begin
        rst_h        = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        csr_gnt_i    = 1'b0;
        window_len_i = '0;
        gap_len_i    = '0;
        num_pkts_i   = '0;
        @(posedge clk_h);

        // Reset state.
        tick(0, 0, 1, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        chk("rst_req", csr_req_o, 0);
        chk("rst_add", csr_add_o, 0);
        chk("rst_pkt", pkt_num_o, 0);
        chk("rst_busy", busy_o, 0);

        // Two packets, window 4, gap 2, grant always high.
        new_test();
        tick(1, 0, 1, 0, 4, 2, 2);
        repeat (16) tick(0, 0, 1, 0, 4, 2, 2);
        chk("t1_en_n", m_en_t.size(), 2);
        chk("t1_en0", m_en_t[0], 1);
        chk("t1_en1", m_en_t[1], 9);
        chk("t1_dis0", m_dis_t[0], 6);
        chk("t1_dis1", m_dis_t[1], 14);
        chk("t1_tr_n", m_tr_t.size(), 10);
        chk("t1_tr_first", m_tr_t[0], 2);
        chk("t1_tr_gap", m_tr_t[5], 10);
        chk("t1_done", m_done_t[0], 14);
        chk("t1_pkt", pkt_num_o, 2);

        // Grant withheld for three cycles in the enable request.
        new_test();
        tick(1, 0, 0, 0, 2, 0, 1);
        repeat (3) tick(0, 0, 0, 0, 2, 0, 1);
        repeat (6) tick(0, 0, 1, 0, 2, 0, 1);
        chk("t2_en", m_en_t[0], 4);
        chk("t2_tr_first", m_tr_t[0], 5);
        chk("t2_dis", m_dis_t[0], 7);
        chk("t2_done", m_done_t[0], 7);
        chk("t2_pkt", pkt_num_o, 1);

        // Abort in the second window cycle of packet 0.
        new_test();
        tick(1, 0, 1, 0, 4, 1, 5);
        repeat (2) tick(0, 0, 1, 0, 4, 1, 5);
        tick(0, 1, 1, 0, 4, 1, 5);
        repeat (5) tick(0, 0, 1, 0, 4, 1, 5);
        chk("t3_en_n", m_en_t.size(), 1);
        chk("t3_dis", m_dis_t[0], 4);
        chk("t3_done", m_done_t[0], 4);
        chk("t3_pkt", pkt_num_o, 1);
        chk("t3_busy", busy_o, 0);

        // Abort during the gap after packet 1, infinite mode.
        new_test();
        tick(1, 0, 1, 0, 2, 3, 0);
        repeat (12) tick(0, 0, 1, 0, 2, 3, 0);
        tick(0, 1, 1, 0, 2, 3, 0);
        repeat (3) tick(0, 0, 1, 0, 2, 3, 0);
        chk("t4_en_n", m_en_t.size(), 2);
        chk("t4_en1", m_en_t[1], 8);
        chk("t4_dis_n", m_dis_t.size(), 2);
        chk("t4_done", m_done_t[0], 13);
        chk("t4_pkt", pkt_num_o, 2);

        // Zero window/gap, infinite mode, stray start mid-run, then abort.
        new_test();
        tick(1, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i < 20; i++) tick((i == 7), 0, 1, 0, 0, 0, 0);
        chk("t5_pkt19", pkt_num_o, 6);
        tick(0, 1, 1, 0, 0, 0, 0);
        repeat (3) tick(0, 0, 1, 0, 0, 0, 0);
        chk("t5_en_n", m_en_t.size(), 7);
        chk("t5_dis_n", m_dis_t.size(), 7);
        chk("t5_done", m_done_t[0], 21);
        chk("t5_pkt", pkt_num_o, 7);

        // Reset while an inhibit request waits for its grant.
        new_test();
        tick(1, 0, 1, 0, 1, 0, 3);
        repeat (5) tick(0, 0, 1, 0, 1, 0, 3);
        tick(0, 0, 0, 1, 1, 0, 3);
        chk("t6_req_in_rst", csr_req_o, 1);
        chk("t6_pkt_in_rst", pkt_num_o, 1);
        tick(0, 0, 0, 0, 1, 0, 3);
        chk("t6_req", csr_req_o, 0);
        chk("t6_tracing", tracing_o, 0);
        chk("t6_pkt", pkt_num_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_done_n", m_done_t.size(), 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0),
                 $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
